// File: rtl/tl_pkg.sv
// Shared definitions for the intersection controller: lamp encodings,
// controller state codes and default phase lengths.
package tl_pkg;

  // One-hot lamp encodings shared by both heads
  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;

  // Default phase lengths in clock cycles
  localparam int T_MAIN_G_DEF = 10;
  localparam int T_SIDE_G_DEF = 10;
  localparam int T_YEL_DEF    = 3;
  localparam int T_ALLRED_DEF = 1;
  localparam int T_WALK_DEF   = 6;
  localparam int CW_DEF       = 5;

  // Controller states; code 7 is unused and recovers to main green
  typedef enum logic [2:0] {
    ST_MAIN_G = 3'd0,
    ST_MAIN_Y = 3'd1,
    ST_AR1    = 3'd2,
    ST_WALK   = 3'd3,
    ST_SIDE_G = 3'd4,
    ST_SIDE_Y = 3'd5,
    ST_AR2    = 3'd6
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: cleared on phase entry, counts up and holds at
// the supplied limit, flagging when the limit has been reached.
module phase_timer #(
  parameter int CW = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, otherwise advance until the limit is hit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != limit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == limit);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection controller with a latched pedestrian walk phase.
// Main road rests on green; lamps are a Moore decode of the state register.
module intersection_ctrl
  import tl_pkg::*;
#(
  parameter int T_MAIN_G = T_MAIN_G_DEF,
  parameter int T_SIDE_G = T_SIDE_G_DEF,
  parameter int T_YEL    = T_YEL_DEF,
  parameter int T_ALLRED = T_ALLRED_DEF,
  parameter int T_WALK   = T_WALK_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_dbg
);

  state_t        state_q;
  state_t        state_d;
  logic          ped_pending_q;
  logic          ped_pending_d;
  logic [CW-1:0] tmr_limit;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_done;
  logic          tmr_clr;

  // Last timer value of each phase (phase of N cycles runs 0..N-1)
  always_comb begin
    tmr_limit = '0;
    case (state_q)
      ST_MAIN_G: tmr_limit = CW'(T_MAIN_G - 1);
      ST_MAIN_Y: tmr_limit = CW'(T_YEL - 1);
      ST_AR1:    tmr_limit = CW'(T_ALLRED - 1);
      ST_WALK:   tmr_limit = CW'(T_WALK - 1);
      ST_SIDE_G: tmr_limit = CW'(T_SIDE_G - 1);
      ST_SIDE_Y: tmr_limit = CW'(T_YEL - 1);
      ST_AR2:    tmr_limit = CW'(T_ALLRED - 1);
      default:   tmr_limit = '0;
    endcase
  end

  assign tmr_clr = (state_d != state_q);

  phase_timer #(.CW(CW)) u_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .cnt   (tmr_cnt),
    .done  (tmr_done)
  );

  // Next-state logic; main green waits on its saturated count plus a request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MAIN_G: if ((tmr_cnt == CW'(T_MAIN_G - 1)) && (side_req || ped_pending_q))
                   state_d = ST_MAIN_Y;
      ST_MAIN_Y: if (tmr_done) state_d = ST_AR1;
      ST_AR1:    if (tmr_done) state_d = ped_pending_q ? ST_WALK : ST_SIDE_G;
      ST_WALK:   if (tmr_done) state_d = side_req ? ST_SIDE_G : ST_AR2;
      ST_SIDE_G: if (tmr_done) state_d = ST_SIDE_Y;
      ST_SIDE_Y: if (tmr_done) state_d = ST_AR2;
      ST_AR2:    if (tmr_done) state_d = ST_MAIN_G;
      default:   state_d = ST_MAIN_G;
    endcase
  end

  // Pedestrian latch: entering the walk phase clears it and wins over a new press
  always_comb begin
    ped_pending_d = ped_pending_q;
    if ((state_d == ST_WALK) && (state_q != ST_WALK)) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != ST_WALK)) begin
      ped_pending_d = 1'b1;
    end
  end

  // State and pedestrian latch registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_MAIN_G;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Lamp decode straight from the state register
  always_comb begin
    main_light = LT_RED;
    side_light = LT_RED;
    walk       = 1'b0;
    case (state_q)
      ST_MAIN_G: main_light = LT_GREEN;
      ST_MAIN_Y: main_light = LT_YELLOW;
      ST_SIDE_G: side_light = LT_GREEN;
      ST_SIDE_Y: side_light = LT_YELLOW;
      ST_WALK:   walk       = 1'b1;
      default:   main_light = LT_RED;
    endcase
  end

  assign ped_pending = ped_pending_q;
  assign state_dbg   = state_q;

endmodule
